dct_block_scheduler: RTL
========================

// Module: dct_block_scheduler
// PURPOSE
// Sequences 8x8 pixel blocks through the dct_2d core for one frame.
// Accepts tagged blocks from the tiler (valid/ready), loads dct_2d's input register bank and pulses start_block.
// Waits for block_done, captures coefficients into the output bank and presents them to the quantizer (valid/ready).
// Counts blocks per frame, flags frame end and raises a sticky error on core timeout.
// PARAMETERS
// TAG_W        12    width of block index tag (row/col packed), passed through unchanged
// CNT_W        16    width of block counter / num_blocks
// TIMEOUT      128   max cycles allowed between start pulse and block_done
// PORTS
// clk          in   1      system clock
// rst          in   1      synchronous reset, active-high
// num_blocks   in   CNT_W  blocks per frame; sampled on the first accepted block of a frame; 0 treated as 1
// in_valid     in   1      tiler has a block in its staging bank
// in_tag       in   TAG_W  block index tag
// in_ready     out  1      scheduler accepts block this cycle
// ld_en        out  1      1-cycle strobe: copy staging bank into dct_2d block input
// start_block  out  1      1-cycle start pulse to dct_2d
// block_done   in   1      dct_2d completion pulse
// cap_en       out  1      1-cycle strobe: copy dct_block_out into output bank
// out_valid    out  1      captured coefficients + tag valid
// out_tag      out  TAG_W  tag of presented block
// out_ready    in   1      quantizer accepts
// frame_done   out  1      1-cycle pulse when last block of frame is accepted downstream
// blk_count    out  CNT_W  blocks completed downstream in current frame
// err_timeout  out  1      sticky; set when block_done absent for TIMEOUT cycles
// BEHAVIOUR
// - Reset: state=IDLE; in_ready, ld_en, start_block, cap_en, out_valid, frame_done, err_timeout = 0; out_tag, blk_count = 0.
// - FSM: IDLE -> LOAD -> START -> BUSY -> CAPTURE -> HOLD -> (IDLE | LOAD).
// - IDLE: in_ready=1 (combinational with state). in_valid&in_ready: latch in_tag, assert ld_en next cycle (LOAD).
// - LOAD: ld_en=1 for exactly 1 cycle -> START. START: start_block=1 for exactly 1 cycle -> BUSY; clear timeout counter.
// - BUSY: wait block_done. Timer increments each BUSY cycle.
//   Timer reaching TIMEOUT sets err_timeout and forces IDLE without capture; the block is dropped and blk_count is unchanged.
// - block_done outside BUSY is ignored (no state change, no error).
//   block_done in the same cycle the timer reaches TIMEOUT counts as done; no error.
// - CAPTURE: cap_en=1 for 1 cycle -> HOLD. out_valid rises the cycle after cap_en; out_tag = latched tag.
// - HOLD: out_valid held, out_tag stable until out_valid&out_ready. On that handshake: blk_count++, out_valid drops next cycle.
//   - If blk_count+1 == frame target: frame_done pulses 1 cycle, blk_count -> 0, new frame target sampled on next accept.
//   - Overlap: in_ready=1 also in HOLD in the handshake cycle. A block accepted then goes directly HOLD -> LOAD (no IDLE bubble).
//     The output bank is already consumed, so reloading is safe.
// - Minimum block latency: accept -> start_block = 2 cycles; block_done -> out_valid = 2 cycles.
// - Only one block in the core at a time; in_ready=0 in LOAD/START/BUSY/CAPTURE.
// - err_timeout clears only on rst. Scheduling continues after an error.
// - rst mid-operation: all state returns to reset values next edge. dct_2d gets its own reset; any later block_done is ignored in IDLE.
// - Counter widths: blk_count wraps only via frame end; num_blocks > 2^CNT_W-1 is not representable.
// STRUCTURE
// - Shared package dct_pkg: sched_state_e enum (IDLE, LOAD, START, BUSY, CAPTURE, HOLD), BLK_N=8, COEF_W=54, PIX_W=9.
// - One sub-module: sched_timeout_ctr (clear, enable, TIMEOUT param -> expired). Everything else in one FSM + counters.
// - Coefficient/pixel banks stay outside; this block drives their enables only.
// TESTING
// - Single block, num_blocks=1, out_ready=1:
//   accept @T -> ld_en @T+1, start_block @T+2; block_done @T+40 -> cap_en @T+41, out_valid @T+42; frame_done with handshake.
// - Back-to-back: num_blocks=4, in_valid always 1, tags 0..3:
//   out_tag order 0,1,2,3; in_ready only in IDLE/HOLD-handshake; frame_done once, blk_count returns 0.
// - Backpressure: out_ready=0 for 20 cycles -> out_valid/out_tag stable, in_ready=0, no second start_block; release -> one handshake.
// - Timeout: TIMEOUT=16, never drive block_done -> err_timeout=1 at 16th BUSY cycle, state IDLE, blk_count unchanged.
//   Next block still completes normally.
// - Stray/edge done: block_done pulse in IDLE -> no outputs change; block_done exactly on TIMEOUT cycle -> capture, err_timeout=0.
// - Reset mid-BUSY: rst for 1 cycle -> all outputs at reset values; subsequent block_done ignored; next in_valid accepted normally.

Source files
------------

// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT block pipeline.
// Scheduler states plus block geometry and datapath widths.
package dct_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    BUSY,
    CAPTURE,
    HOLD
  } sched_state_e;

  localparam int BLK_N  = 8;
  localparam int COEF_W = 54;
  localparam int PIX_W  = 9;

endpackage

// File: rtl/sched_timeout_ctr.sv
// Watchdog for the dct_2d core: counts enabled cycles since clear.
// expired is asserted during the cycle in which the count reaches TIMEOUT.
module sched_timeout_ctr #(
  parameter int TIMEOUT = 128
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  // this enabled cycle is the TIMEOUT-th one
  assign expired = enable && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/dct_block_scheduler.sv
// Sequences 8x8 blocks through dct_2d: load, start, wait, capture, present.
// Tracks per-frame block count, frame end and a sticky core timeout flag.
module dct_block_scheduler
  import dct_pkg::*;
#(
  parameter int TAG_W   = 12,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] num_blocks,
  input  logic             in_valid,
  input  logic [TAG_W-1:0] in_tag,
  output logic             in_ready,
  output logic             ld_en,
  output logic             start_block,
  input  logic             block_done,
  output logic             cap_en,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ready,
  output logic             frame_done,
  output logic [CNT_W-1:0] blk_count,
  output logic             err_timeout
);

  sched_state_e     state;
  sched_state_e     state_nx;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] target;
  logic             frame_open;
  logic             expired;
  logic             accept;
  logic             hs;
  logic             last;
  logic             timeout_hit;

  sched_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_block),
    .enable (state == BUSY),
    .expired(expired)
  );

  assign ld_en       = (state == LOAD);
  assign start_block = (state == START);
  assign cap_en      = (state == CAPTURE);
  assign out_valid   = (state == HOLD);
  assign out_tag     = tag_q;

  // HOLD may take the next block in the same cycle its result leaves
  assign in_ready = !rst &&
    ((state == IDLE) || ((state == HOLD) && out_ready));

  assign accept      = in_valid && in_ready;
  assign hs          = out_valid && out_ready;
  assign last        = hs && ((blk_count + CNT_W'(1)) == target);
  assign frame_done  = last;
  assign timeout_hit = (state == BUSY) && expired && !block_done;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = LOAD;
      LOAD:    state_nx = START;
      START:   state_nx = BUSY;
      BUSY: begin
        if (block_done)   state_nx = CAPTURE;
        else if (expired) state_nx = IDLE;
      end
      CAPTURE: state_nx = HOLD;
      HOLD: begin
        if (hs) state_nx = accept ? LOAD : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tag_q       <= '0;
      target      <= CNT_W'(1);
      frame_open  <= 1'b0;
      blk_count   <= '0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) tag_q <= in_tag;
      if (timeout_hit) err_timeout <= 1'b1;
      if (hs) blk_count <= last ? '0 : blk_count + CNT_W'(1);
      if (last) frame_open <= 1'b0;
      // first block of a frame fixes the frame length
      if (accept && (!frame_open || last)) begin
        target     <= (num_blocks == '0) ? CNT_W'(1) : num_blocks;
        frame_open <= 1'b1;
      end
    end
  end

endmodule
